// File: rtl/cla_sub32_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: diff = dina - dinb - bin.
// Stage 1 resolves the low half and its carry. Stage 2 resolves the high half
// and registers the result and flags. valid/ready handshake on both sides.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   dina, dinb, bin     minuend, subtrahend, borrow-in
//   out_valid/out_ready result handshake
//   diff, bout          difference mod 2^WIDTH, unsigned borrow-out
//   ovf, zero           signed overflow, diff == 0
module cla_sub32_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned HW = WIDTH / 2;        // bits per stage
  localparam int unsigned NG = (HW + 3) / 4;     // 4-bit lookahead groups per half
  localparam int unsigned PW = NG * 4;           // half width padded to whole groups

  // Half-width adder with 4-bit group generate/propagate lookahead.
  // Returns {carry_out, sum}.
  function automatic logic [HW:0] cla_half(input logic [HW-1:0] a,
                                           input logic [HW-1:0] b,
                                           input logic          cin);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;
    logic          gg;
    logic          pp;
    g    = PW'(a) & PW'(b);
    p    = PW'(a) ^ PW'(b);
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < int'(NG); k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp = &p[4*k +: 4];
      // Bit carries inside the group, from the group carry-in.
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      // Group carry-out straight from group G/P.
      c[4*k+4] = gg | (pp & c[4*k]);
    end
    return {c[HW], p[HW-1:0] ^ c[HW-1:0]};
  endfunction

  logic          r_s1_valid;
  logic [HW-1:0] r_s1_dlo;
  logic          r_s1_clo;
  logic [HW-1:0] r_s1_ahi;
  logic [HW-1:0] r_s1_bhi;

  logic [HW:0]    w_lo;
  logic [HW:0]    w_hi;
  logic [WIDTH-1:0] w_diff;
  logic           w_s2_load;
  logic           w_accept;

  // Subtraction as a + ~b + ~bin; carry-out is the inverted borrow.
  assign w_lo   = cla_half(dina[HW-1:0], ~dinb[HW-1:0], ~bin);
  assign w_hi   = cla_half(r_s1_ahi, ~r_s1_bhi, r_s1_clo);
  assign w_diff = {w_hi[HW-1:0], r_s1_dlo};

  assign w_s2_load = r_s1_valid & (~out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign w_accept  = in_valid & in_ready;

  // Stage 1: low-half result, low carry, and high operand halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_dlo   <= '0;
      r_s1_clo   <= 1'b0;
      r_s1_ahi   <= '0;
      r_s1_bhi   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_dlo   <= w_lo[HW-1:0];
      r_s1_clo   <= w_lo[HW];
      r_s1_ahi   <= dina[WIDTH-1:HW];
      r_s1_bhi   <= dinb[WIDTH-1:HW];
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (w_s2_load) begin
      out_valid <= 1'b1;
      diff      <= w_diff;
      bout      <= ~w_hi[HW];
      // Operand signs differ and the result sign differs from the minuend.
      ovf       <= (r_s1_ahi[HW-1] ^ r_s1_bhi[HW-1]) & (w_hi[HW-1] ^ r_s1_ahi[HW-1]);
      zero      <= ~|w_diff;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
